muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide resource. It accepts one M-extension operation from the main controller and runs a shift-add multiply or restoring divide, one bit per cycle. It applies sign correction, then signals completion on exdone. It sits beside the ALU in the datapath; the controller drives start/op and stalls in its execute state until exdone.

---
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RV32M multiply/divide sequencer. Shift-add multiply or
//            restoring divide, one bit per cycle, with sign fix-up and a
//            one-cycle exdone pulse on completion.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            busy,
    output logic            exdone,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int                 CW         = $clog2(XLEN + 1);
    localparam logic [CW-1:0]      C_ITERS    = CW'(XLEN);
    localparam logic [CW-1:0]      C_CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]    C_ZERO     = '0;
    localparam logic [XLEN-1:0]    C_ONES     = '1;
    localparam logic [XLEN-1:0]    C_ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0]  C_ONE_2X   = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]    C_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] C_OP_MUL    = 3'b000;
    localparam logic [2:0] C_OP_MULH   = 3'b001;
    localparam logic [2:0] C_OP_MULHSU = 3'b010;
    localparam logic [2:0] C_OP_MULHU  = 3'b011;
    localparam logic [2:0] C_OP_DIV    = 3'b100;
    localparam logic [2:0] C_OP_DIVU   = 3'b101;
    localparam logic [2:0] C_OP_REM    = 3'b110;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_opa;
    logic [XLEN-1:0]     r_opb;
    logic [CW-1:0]       r_cnt;
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0]   r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]     r_opnd;
    logic                r_neg_main;
    logic                r_neg_rem;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic                w_ge;
    logic [XLEN-1:0]     w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_sel;

    // Operand conditioning, one iteration step and final sign fix-up/selection.
    always_comb begin
        w_is_div   = r_op[2];
        w_a_signed = (r_op == C_OP_MULH) || (r_op == C_OP_MULHSU) ||
                     (r_op == C_OP_DIV)  || (r_op == C_OP_REM);
        w_b_signed = (r_op == C_OP_MULH) || (r_op == C_OP_DIV) || (r_op == C_OP_REM);
        w_sign_a   = w_a_signed & r_opa[XLEN-1];
        w_sign_b   = w_b_signed & r_opb[XLEN-1];
        w_mag_a    = w_sign_a ? (~r_opa + C_ONE) : r_opa;
        w_mag_b    = w_sign_b ? (~r_opb + C_ONE) : r_opb;

        // Special divide cases bypass the iteration entirely.
        w_div_zero = w_is_div && (r_opb == C_ZERO);
        w_div_ovf  = w_is_div && !r_op[0] && (r_opa == C_MIN_NEG) && (r_opb == C_ONES);

        // Shift-add multiply: conditional add into the upper half, then shift
        // right with the adder carry entering at the top.
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

        // Restoring divide: the shifted remainder needs one extra bit because
        // the divisor magnitude can use the full XLEN.
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opnd});
        w_diff     = w_rem_sh[XLEN-1:0] - r_opnd;
        w_div_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                          : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

        w_prod     = r_neg_main ? (~r_acc + C_ONE_2X) : r_acc;
        w_quot     = r_neg_main ? (~r_acc[XLEN-1:0] + C_ONE) : r_acc[XLEN-1:0];
        w_rem      = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + C_ONE) : r_acc[2*XLEN-1:XLEN];

        case (r_op)
            C_OP_MUL:                          w_fix_sel = w_prod[XLEN-1:0];
            C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: w_fix_sel = w_prod[2*XLEN-1:XLEN];
            C_OP_DIV, C_OP_DIVU:               w_fix_sel = w_quot;
            default:                           w_fix_sel = w_rem;
        endcase
    end

    // Sequencer FSM with registered busy/exdone/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 3'b000;
            r_opa      <= C_ZERO;
            r_opb      <= C_ZERO;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= C_ZERO;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            busy       <= 1'b0;
            exdone     <= 1'b0;
            result     <= C_ZERO;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    exdone <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_opa   <= opa;
                        r_opb   <= opb;
                        r_cnt   <= C_ITERS;
                        busy    <= 1'b1;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_neg_main <= w_sign_a ^ w_sign_b;
                    r_neg_rem  <= w_sign_a;
                    if (w_is_div) begin
                        r_acc  <= {C_ZERO, w_mag_a};
                        r_opnd <= w_mag_b;
                    end else begin
                        r_acc  <= {C_ZERO, w_mag_b};
                        r_opnd <= w_mag_a;
                    end
                    if (w_div_zero) begin
                        // Quotient all ones, remainder is the raw dividend.
                        result  <= r_op[1] ? r_opa : C_ONES;
                        busy    <= 1'b0;
                        exdone  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_div_ovf) begin
                        result  <= r_op[1] ? C_ZERO : C_MIN_NEG;
                        busy    <= 1'b0;
                        exdone  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (r_cnt == C_CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result  <= w_fix_sel;
                    busy    <= 1'b0;
                    exdone  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    exdone  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq; directed cases plus random
//            operations against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

    localparam int XLEN    = 32;
    localparam int LAT_NRM = 34;   // edges from accept edge to the edge raising exdone
    localparam int LAT_SPC = 1;
    localparam int BSY_NRM = 34;   // PREP + 32 ITER + FIX

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            busy;
    logic            exdone;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .exdone (exdone),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics using 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = 64'h0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return LAT_SPC;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return LAT_SPC;
        return LAT_NRM;
    endfunction

    // Drives start for one edge from the current time; returns when exdone
    // is seen (sampled #1 after each edge) or after a bounded wait.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bsy, output int both);
        op = f; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bsy = 0; both = 0;
        while (!exdone && lat < 100) begin
            if (busy) bsy++;
            @(posedge clk); #1;
            lat++;
            if (busy && exdone) both++;
        end
        res = result;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (exdone !== 1'b0) begin n_err++; $display("FAIL reset_exdone got=%b exp=0", exdone); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_mul_basic();
        logic [31:0] r; int lat, bsy, both;
        do_op(3'd0, 32'hFFFFFFFF, 32'd7, r, lat, bsy, both);
        n_cmp++; if (r !== 32'hFFFFFFF9) begin n_err++; $display("FAIL mul_result got=%h exp=fffffff9", r); end
        n_cmp++; if (lat !== LAT_NRM) begin n_err++; $display("FAIL mul_latency got=%0d exp=%0d", lat, LAT_NRM); end
        n_cmp++; if (bsy !== BSY_NRM) begin n_err++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", bsy, BSY_NRM); end
        n_cmp++; if (both !== 0) begin n_err++; $display("FAIL mul_busy_and_exdone got=%0d exp=0", both); end
        idle_cycle();
        n_cmp++; if (exdone !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b exp=0", exdone); end
        n_cmp++; if (result !== 32'hFFFFFFF9) begin n_err++; $display("FAIL result_hold got=%h exp=fffffff9", result); end
    endtask

    task automatic test_mulh_family();
        logic [31:0] r; int lat, bsy, both;
        logic [31:0] exp_v [3] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 3; i++) begin
            do_op(3'(i + 1), 32'h80000000, 32'hFFFFFFFF, r, lat, bsy, both);
            n_cmp++; if (r !== exp_v[i]) begin n_err++; $display("FAIL mulh_op%0d got=%h exp=%h", i + 1, r, exp_v[i]); end
            idle_cycle();
        end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, bsy, both;
        logic [2:0]  f_v [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] a_v [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b_v [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e_v [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            do_op(f_v[i], a_v[i], b_v[i], r, lat, bsy, both);
            n_cmp++; if (r !== e_v[i]) begin n_err++; $display("FAIL div_case%0d got=%h exp=%h", i, r, e_v[i]); end
            n_cmp++; if (lat !== LAT_NRM) begin n_err++; $display("FAIL div_latency%0d got=%0d exp=%0d", i, lat, LAT_NRM); end
            idle_cycle();
        end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat, bsy, both;
        logic [2:0]  f_v [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] a_v [4] = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] b_v [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e_v [4] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_op(f_v[i], a_v[i], b_v[i], r, lat, bsy, both);
            n_cmp++; if (r !== e_v[i]) begin n_err++; $display("FAIL special%0d got=%h exp=%h", i, r, e_v[i]); end
            n_cmp++; if (lat !== LAT_SPC) begin n_err++; $display("FAIL special_latency%0d got=%0d exp=%0d", i, lat, LAT_SPC); end
            n_cmp++; if (both !== 0) begin n_err++; $display("FAIL special_busy_and_exdone%0d got=%0d exp=0", i, both); end
            idle_cycle();
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        op = 3'd2; opa = 32'hC0FFEE01; opb = 32'h00012345; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs; the latched operands must not change.
        op = 3'd5; opa = 32'h0; opb = 32'h0;
        lat = 0;
        while (!exdone && lat < 100) begin
            start = (lat == 5 || lat == 20);
            opa = $urandom; opb = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_cmp++; if (result !== ref_res(3'd2, 32'hC0FFEE01, 32'h00012345)) begin
            n_err++; $display("FAIL ignore_start_result got=%h exp=%h", result, ref_res(3'd2, 32'hC0FFEE01, 32'h00012345));
        end
        n_cmp++; if (lat !== LAT_NRM) begin n_err++; $display("FAIL ignore_start_latency got=%0d exp=%0d", lat, LAT_NRM); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bsy, both;
        logic [2:0]  f_v [3] = '{3'd0, 3'd4, 3'd3};
        logic [31:0] a_v [3] = '{32'h0001_0003, 32'hFFFF_FF00, 32'hDEAD_BEEF};
        logic [31:0] b_v [3] = '{32'h0002_0005, 32'h0000_0010, 32'hCAFE_F00D};
        // Each call after the first begins in the DONE cycle of the previous one.
        for (int i = 0; i < 3; i++) begin
            do_op(f_v[i], a_v[i], b_v[i], r, lat, bsy, both);
            n_cmp++; if (r !== ref_res(f_v[i], a_v[i], b_v[i])) begin
                n_err++; $display("FAIL b2b_result%0d got=%h exp=%h", i, r, ref_res(f_v[i], a_v[i], b_v[i]));
            end
            n_cmp++; if (lat !== LAT_NRM) begin n_err++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", i, lat, LAT_NRM); end
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat, bsy, both, spurious;
        op = 3'd0; opa = 32'h1234_5678; opb = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);   // PREP edge + 10 ITER steps
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        n_cmp++; if (exdone !== 1'b0) begin n_err++; $display("FAIL midreset_exdone got=%b exp=0", exdone); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midreset_result got=%h exp=0", result); end
        spurious = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (exdone || busy) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL midreset_spurious got=%0d exp=0", spurious); end
        do_op(3'd6, 32'hFFFF_FF85, 32'd10, r, lat, bsy, both);
        n_cmp++; if (r !== ref_res(3'd6, 32'hFFFF_FF85, 32'd10)) begin
            n_err++; $display("FAIL after_reset_result got=%h exp=%h", r, ref_res(3'd6, 32'hFFFF_FF85, 32'd10));
        end
        idle_cycle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] r, a, b; logic [2:0] f; int lat, bsy, both;
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_op(f, a, b, r, lat, bsy, both);
            n_cmp++; if (r !== ref_res(f, a, b)) begin
                n_err++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, r, ref_res(f, a, b));
            end
            n_cmp++; if (lat !== ref_lat(f, a, b)) begin
                n_err++; $display("FAIL rand_latency%0d op=%0d got=%0d exp=%0d", i, f, lat, ref_lat(f, a, b));
            end
            n_cmp++; if (both !== 0) begin n_err++; $display("FAIL rand_busy_and_exdone%0d got=%0d exp=0", i, both); end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulh_family();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
